// File: rtl/iterative_multiplier.sv
// iterative_multiplier
//   Iterative shift-and-add multiplier with valid/ready handshakes on both
//   sides. Signed operands are reduced to magnitudes on accept and the sign
//   is restored on the final product. BitsPerCycle multiplier bits are
//   retired per BUSY cycle, so a product takes N = Width/BitsPerCycle cycles.
//
// Parameters
//   Width         operand width in bits (>= 2)
//   BitsPerCycle  multiplier bits retired per iteration (1..Width, divides Width)
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_ni       synchronous active-low reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept operands (IDLE only)
//   in_signed_i  1 = two's complement operands, 0 = unsigned
//   in_a_i       multiplicand
//   in_b_i       multiplier
//   out_valid_o  product valid (DONE only)
//   out_ready_i  consumer accepts product
//   out_data_o   2*Width-bit product, held until the next result
//   busy_o       high whenever the FSM is not IDLE
module iterative_multiplier #(
  parameter int Width        = 8,
  parameter int BitsPerCycle = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_signed_i,
  input  logic [Width-1:0]     in_a_i,
  input  logic [Width-1:0]     in_b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*Width-1:0]   out_data_o,
  output logic                 busy_o
);

  // Guarded divisor so a zero BitsPerCycle reaches the check below instead
  // of tripping a divide-by-zero first.
  localparam int SafeBpc = (BitsPerCycle > 0) ? BitsPerCycle : 1;
  localparam int N       = Width / SafeBpc;
  localparam int CntW    = (N > 1) ? $clog2(N) : 1;
  localparam int ProdW   = 2 * Width;

  localparam logic [CntW-1:0] LastIter = CntW'(N - 1);

  if (Width < 2 || BitsPerCycle < 1 || BitsPerCycle > Width ||
      (Width % SafeBpc) != 0) begin : g_param_check
    $error("iterative_multiplier: illegal Width/BitsPerCycle combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                 state;
  logic [CntW-1:0]        cnt;
  logic [ProdW-1:0]       mcand;    // |a|, pre-shifted to the current digit position
  logic [Width-1:0]       mplier;   // |b|, consumed from the low end
  logic [ProdW-1:0]       acc;
  logic [ProdW-1:0]       acc_next;
  logic [ProdW-1:0]       partial;
  logic [BitsPerCycle-1:0] digit;
  logic                   negate;

  // Unsigned magnitude of an operand. The most negative value maps to
  // 2^(Width-1), which still fits in Width unsigned bits.
  function automatic logic [Width-1:0] magnitude(input logic [Width-1:0] v,
                                                 input logic sgn);
    return (sgn && v[Width-1]) ? (~v + Width'(1)) : v;
  endfunction

  // NOTE: every variable assigned in an always_comb gets a value on every
  // path (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    digit    = mplier[BitsPerCycle-1:0];
    partial  = mcand * {{(ProdW-BitsPerCycle){1'b0}}, digit};
    acc_next = acc + partial;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others. The whole
  // datapath is reset here (it is plain flops, not a memory) because the
  // cleared output value is observable after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      negate      <= 1'b0;
      out_data_o  <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            mcand      <= ProdW'(magnitude(in_a_i, in_signed_i));
            mplier     <= magnitude(in_b_i, in_signed_i);
            negate     <= in_signed_i & (in_a_i[Width-1] ^ in_b_i[Width-1]);
            acc        <= '0;
            cnt        <= '0;
            state      <= BUSY;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end

        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << BitsPerCycle;
          mplier <= mplier >> BitsPerCycle;
          cnt    <= cnt + CntW'(1);
          if (cnt == LastIter) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
            // A zero magnitude negates to zero modulo 2^ProdW, so no -0.
            out_data_o  <= negate ? (~acc_next + ProdW'(1)) : acc_next;
          end
        end

        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/iterative_multiplier.md
ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

Interface
REQ-001 SHALL have parameter Width, default 8: operand width in bits; legal range 2 or more.
REQ-002 SHALL have parameter BitsPerCycle, default 1: multiplier bits retired per iteration; legal range 1..Width, and Width SHALL be a multiple of BitsPerCycle.
REQ-003 SHALL fail elaboration if REQ-001 or REQ-002 constraints are violated.
REQ-004 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_ni  input  1  reset, synchronous and active-low.
REQ-006 in_valid_i  input  1  operand pair valid.
REQ-007 in_ready_o  output  1  block can accept operands.
REQ-008 in_signed_i  input  1  1 = both operands two's complement; 0 = both unsigned.
REQ-009 in_a_i  input  Width  multiplicand.
REQ-010 in_b_i  input  Width  multiplier.
REQ-011 out_valid_o  output  1  product valid.
REQ-012 out_ready_i  input  1  consumer accepts product.
REQ-013 out_data_o  output  2*Width  product.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 Define N = Width/BitsPerCycle; FSM states IDLE, BUSY, DONE.
REQ-016 in_ready_o SHALL equal 1 only in IDLE; out_valid_o SHALL equal 1 only in DONE.
REQ-017 Accept: on an edge where state is IDLE and in_valid_i=1, capture in_signed_i, in_a_i and in_b_i, go to BUSY, and clear the iteration counter.
REQ-018 IDLE with in_valid_i=0 SHALL remain in IDLE; input data is ignored when in_ready_o=0.
REQ-019 Signed mode: the block SHALL latch magnitudes |a| and |b| (Width-bit unsigned) and a negate flag = sign(a) XOR sign(b); unsigned mode SHALL clear the negate flag.
REQ-020 BUSY: each edge SHALL add (|a| x the next BitsPerCycle low bits of |b|) into a 2*Width accumulator at the matching shift, and increment the counter.
REQ-021 After exactly N BUSY edges, the FSM SHALL enter DONE; out_valid_o rises N edges after the accept edge.
REQ-022 On DONE entry, out_data_o SHALL be registered as the accumulator, two's-complement negated (modulo 2^(2*Width)) if the negate flag is set.
REQ-023 Result: unsigned mode a*b exactly; signed mode the exact signed product in 2*Width bits, including (-2^(Width-1))^2 = 2^(2*Width-2).
REQ-024 DONE with out_ready_i=0 SHALL hold state and keep out_data_o stable.
REQ-025 DONE with out_ready_i=1 SHALL go to IDLE on that edge; out_data_o SHALL retain its last value until the next DONE entry.
REQ-026 No overlap: the minimum spacing between accept edges is N+2 cycles when out_ready_i is held high.
REQ-027 Changes of in_* or out_ready_i while BUSY SHALL NOT affect the computation.
REQ-028 Zero operand: the block SHALL still take N cycles and SHALL produce 0; the result SHALL never be -0 or a nonzero value.

Reset
REQ-029 With rst_ni=0 at an edge: state IDLE, counter 0, accumulator 0, negate flag 0, and out_data_o 0.
REQ-030 Output values during and after reset: in_ready_o 1 (the cycle after the reset edge), out_valid_o 0, and busy_o 0.
REQ-031 Reset asserted in BUSY or DONE SHALL abandon the operation with no output handshake; the next accept SHALL compute correctly.
REQ-032 in_valid_i sampled while rst_ni=0 SHALL NOT be accepted.

Verification (Width=8, BitsPerCycle=1 unless noted)
REQ-033 Unsigned 255 x 255, out_ready_i=1 -> out_data_o=0xFE01 with out_valid_o high exactly 8 edges after accept, for one cycle.
REQ-034 Signed -128 x -128 -> 0x4000; signed -1 x 1 -> 0xFFFF; signed 127 x -128 -> 0xC080.
REQ-035 Backpressure: 13 x 11 with out_ready_i=0 for 5 cycles after out_valid_o -> out_data_o=0x008F stable, in_ready_o=0 throughout, accepted on the first out_ready_i=1 edge.
REQ-036 Reset mid-operation: rst_ni=0 at BUSY iteration 3 -> next cycle in_ready_o=1, out_valid_o=0, out_data_o=0; then 7 x 6 -> 0x002A.
REQ-037 Width=16, BitsPerCycle=4: signed 0x8000 x 0x0003 -> 0xFFFE8000 after 4 cycles; in_valid_i held high back-to-back -> accepts spaced by 6 cycles.
REQ-038 Random: 10k random operand pairs and random modes with random out_ready_i -> every product matches a reference model; there are no lost or duplicated results.
